// File: rtl/serial_word_tx.sv
// serial_word_tx
//   Parallel-to-serial transmitter for the MSB-first serial bit-stream
//   interface. A word and its bit length are taken over a valid/ready
//   handshake. The word is then sent one bit per transfer, MSB first. Each
//   bit carries the running remainder of the bits sent so far modulo
//   DIVISOR, together with a divisible flag.
//
//   Ports
//     clk, resetn          clock (rising edge); synchronous active-low reset
//     in_valid/in_ready    word handshake
//     in_data, in_len      word, number of bits to send (0 = drop, >WIDTH clamps)
//     out_valid/out_ready  bit handshake
//     out_bit              current serial bit
//     out_first/out_last   bit is MSB / LSB of its word
//     out_rem, out_div     running remainder including out_bit; out_rem == 0
//
//   state | meaning
//   IDLE  | no word loaded, ready for a new word
//   SHIFT | presenting the bits of a loaded word
module serial_word_tx #(
   parameter int WIDTH   = 16,
   parameter int DIVISOR = 3,
   parameter int LEN_W   = $clog2(WIDTH + 1),
   parameter int REM_W   = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LEN_W-1:0] in_len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic             out_first,
   output logic             out_last,
   output logic [REM_W-1:0] out_rem,
   output logic             out_div
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
   localparam logic [REM_W:0]   DIV_L   = (REM_W + 1)'(DIVISOR);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             bit_q, bit_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic             div_q, div_d;

   logic [LEN_W-1:0] eff_len;
   logic [WIDTH-1:0] aligned;
   logic             xfer;
   logic             accept;

   // {prefix, b} is 2*prefix + b. It is below 2*DIVISOR, so a single
   // conditional subtract gives the exact remainder.
   function automatic logic [REM_W-1:0] rem_step(input logic [REM_W-1:0] prefix,
                                                 input logic b);
      logic [REM_W:0] acc;
      acc = {prefix, b};
      if (acc >= DIV_L) acc = acc - DIV_L;
      return acc[REM_W-1:0];
   endfunction

   assign in_ready  = resetn && ((state_q == IDLE) || (last_q && out_ready));
   assign out_valid = (state_q == SHIFT);
   assign out_bit   = bit_q;
   assign out_first = first_q;
   assign out_last  = last_q;
   assign out_rem   = rem_q;
   assign out_div   = div_q;

   always_comb begin
      eff_len = (in_len > WIDTH_L) ? WIDTH_L : in_len;
      // Left-justify the word so the next bit to send is always the top bit.
      aligned = in_data << (WIDTH_L - eff_len);
      xfer    = (state_q == SHIFT) && out_ready;
      accept  = in_valid && in_ready;

      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      first_d = first_q;
      last_d  = last_q;
      rem_d   = rem_q;
      div_d   = div_q;

      if (xfer) begin
         if (last_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            rem_d   = '0;
            div_d   = 1'b0;
         end else begin
            bit_d   = shift_q[WIDTH-1];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - 1'b1;
            first_d = 1'b0;
            last_d  = (cnt_d == LEN_W'(1));
            rem_d   = rem_step(rem_q, shift_q[WIDTH-1]);
            div_d   = (rem_d == '0);
         end
      end

      // A new word overrides the end-of-word return to IDLE, so a word
      // accepted on the last-bit transfer follows with no bubble.
      if (accept && (eff_len != '0)) begin
         state_d = SHIFT;
         bit_d   = aligned[WIDTH-1];
         shift_d = aligned << 1;
         cnt_d   = eff_len;
         first_d = 1'b1;
         last_d  = (eff_len == LEN_W'(1));
         rem_d   = rem_step('0, aligned[WIDTH-1]);
         div_d   = (rem_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         bit_q   <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         rem_q   <= '0;
         div_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         first_q <= first_d;
         last_q  <= last_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
      end
   end

endmodule

// File: tb/tb_serial_word_tx.sv
// Testbench for serial_word_tx. It drives two instances (DIVISOR 3 and 5)
// from the same stimulus. Each instance has its own queue of expected bits.
module tb_serial_word_tx;

   localparam int WIDTH = 16;
   localparam int LEN_W = 5;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic [LEN_W-1:0] in_len = '0;
   logic             out_ready = 1'b0;

   logic       in_ready3, out_valid3, bit3, first3, last3, div3;
   logic [1:0] rem3;
   logic       in_ready5, out_valid5, bit5, first5, last5, div5;
   logic [2:0] rem5;

   serial_word_tx #(.WIDTH(WIDTH), .DIVISOR(3)) dut3 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready3),
      .in_data(in_data), .in_len(in_len), .out_valid(out_valid3),
      .out_ready(out_ready), .out_bit(bit3), .out_first(first3),
      .out_last(last3), .out_rem(rem3), .out_div(div3));

   serial_word_tx #(.WIDTH(WIDTH), .DIVISOR(5)) dut5 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready5),
      .in_data(in_data), .in_len(in_len), .out_valid(out_valid5),
      .out_ready(out_ready), .out_bit(bit5), .out_first(first5),
      .out_last(last5), .out_rem(rem5), .out_div(div5));

   always #5 clk = ~clk;

   typedef struct {
      logic b;
      logic f;
      logic l;
      int   rem;
   } exp_t;

   exp_t q[2][$];
   int   checks = 0;
   int   errors = 0;
   bit   after_rst[2];
   bit   rand_ready = 1'b0;

   function automatic void chk(string name, int idx, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", name, idx, act, exp, $time);
      end
   endfunction

   // Reference: bit k is the k-th MSB of the kept low bits. Its remainder is
   // the numeric value of the prefix up to and including bit k, mod divisor.
   function automatic void push_word(int idx, int divisor, logic [WIDTH-1:0] data,
                                     logic [LEN_W-1:0] len);
      int   eff;
      int   word;
      exp_t e;
      eff = (int'(len) > WIDTH) ? WIDTH : int'(len);
      if (eff == 0) return;
      word = int'(data) & ((1 << eff) - 1);
      for (int k = 0; k < eff; k++) begin
         e.b   = 1'((word >> (eff - 1 - k)) & 1);
         e.f   = (k == 0);
         e.l   = (k == eff - 1);
         e.rem = (word >> (eff - 1 - k)) % divisor;
         q[idx].push_back(e);
      end
   endfunction

   task automatic mon(int idx, int divisor, logic ir, logic v, logic b, logic f,
                      logic l, int r, logic d);
      exp_t e;
      logic exp_ir;
      if (!resetn) begin
         chk("in_ready_in_reset", idx, int'(ir), 0);
         q[idx].delete();
         after_rst[idx] = 1'b1;
         return;
      end
      if (after_rst[idx]) begin
         chk("post_reset_outputs", idx, int'({v, b, f, l, d}) + (r << 5), 0);
         after_rst[idx] = 1'b0;
      end
      exp_ir = (q[idx].size() == 0) || (q[idx][0].l && out_ready);
      chk("in_ready", idx, int'(ir), int'(exp_ir));
      if (v) begin
         chk("bits_pending_when_valid", idx, int'(q[idx].size() > 0), 1);
         if (q[idx].size() > 0) begin
            e = q[idx][0];
            chk("out_bit", idx, int'(b), int'(e.b));
            chk("out_first", idx, int'(f), int'(e.f));
            chk("out_last", idx, int'(l), int'(e.l));
            chk("out_rem", idx, r, e.rem);
            chk("out_div", idx, int'(d), int'(e.rem == 0));
            if (out_ready) void'(q[idx].pop_front());
         end
      end else begin
         chk("idle_with_bits_pending", idx, q[idx].size(), 0);
      end
      if (in_valid && exp_ir) push_word(idx, divisor, in_data, in_len);
   endtask

   // Everything is stable at the falling edge. A handshake seen here
   // completes on the next rising edge.
   always @(negedge clk) begin
      mon(0, 3, in_ready3, out_valid3, bit3, first3, last3, int'(rem3), div3);
      mon(1, 5, in_ready5, out_valid5, bit5, first5, last5, int'(rem5), div5);
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(logic [WIDTH-1:0] d, logic [LEN_W-1:0] l);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_len   = l;
      for (int n = 0; n < 300 && !acc; n++) begin
         #1;
         acc = in_ready3;
         tick();
      end
      in_valid = 1'b0;
      chk("accept_timeout", 0, int'(acc), 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q[0].size() != 0 || q[1].size() != 0 || out_valid3 || out_valid5) && n < 300) begin
         tick();
         n++;
      end
      chk("drain_timeout", 0, int'(n < 300), 1);
   endtask

   initial begin
      out_ready = 1'b1;
      repeat (3) tick();
      resetn = 1'b1;
      tick();

      send(16'h0006, 5'd3);
      wait_idle();

      send(16'h0006, 5'd3);
      tick();
      out_ready = 1'b0;
      tick();
      tick();
      out_ready = 1'b1;
      wait_idle();

      send(16'h0005, 5'd3);
      send(16'h0009, 5'd4);
      wait_idle();

      send(16'hABCD, 5'd0);
      tick();
      send(16'h0001, 5'd1);
      wait_idle();

      send(16'hFFFF, 5'd16);
      repeat (5) tick();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      send(16'h0003, 5'd2);
      wait_idle();

      send(16'h0019, 5'd5);
      wait_idle();

      send(16'hF0F3, 5'd20);
      wait_idle();

      rand_ready = 1'b1;
      for (int w = 0; w < 300; w++) begin
         repeat ($urandom_range(0, 2)) tick();
         send(WIDTH'($urandom), LEN_W'($urandom_range(0, 20)));
      end
      rand_ready = 1'b0;
      tick();
      out_ready = 1'b1;
      wait_idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter for the team's MSB-first serial bit-stream interface, the producer side feeding the serial divisibility/remainder checkers.
- Accepts a word plus a bit length over a valid/ready handshake and emits the word one bit per transfer, MSB first.
- Each emitted bit carries a reference running remainder (cumulative value mod DIVISOR) and a divisible flag, so checker benches can compare against it directly.

Parameters:
- WIDTH, 16, maximum word length in bits (>=1).
- DIVISOR, 3, modulus for the reference remainder (>=2).
- LEN_W, $clog2(WIDTH+1), width of in_len.
- REM_W, max(1,$clog2(DIVISOR)), width of out_rem.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  word offered.
- in_ready  out  1  word accepted on the edge where in_valid && in_ready.
- in_data  in  WIDTH  word; only in_data[len-1:0] is transmitted.
- in_len  in  LEN_W  number of bits to send; 0 means drop the word; values >WIDTH are clamped to WIDTH.
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  sink accepts a bit; a transfer occurs when out_valid && out_ready.
- out_bit  out  1  current serial bit.
- out_first  out  1  current bit is the MSB of its word.
- out_last  out  1  current bit is the LSB of its word.
- out_rem  out  REM_W  cumulative value of the word's bits sent so far, including out_bit, mod DIVISOR.
- out_div  out  1  out_rem == 0.

Behaviour:
- Reset (resetn low at an edge):
  - State goes to IDLE; any word in flight is discarded with no further bits.
  - Registered outputs are 0 after the edge: out_valid, out_bit, out_first, out_last, out_rem, out_div.
  - in_ready is forced 0 while resetn is low.
- States:
  - IDLE: no word loaded; out_valid=0; in_ready=1.
  - SHIFT: a word is loaded; out_valid=1.
- Accept:
  - An accept is in_valid && in_ready at an edge.
  - With eff_len>=1, the shift register loads in_data, the bit counter loads eff_len, the prefix remainder clears to 0, and the state goes to SHIFT.
  - Latency: the first bit (in_data[eff_len-1], out_first=1) is on the outputs in the cycle after the accepting edge.
  - With in_len==0 the word is consumed and no bits are emitted; the state stays or returns to IDLE.
- Bit values:
  - Bit k (k=0 first) = in_data[eff_len-1-k].
  - out_rem for bit k = (2*prefix_rem + bit_k) mod DIVISOR, where prefix_rem is the remainder after bit k-1 (0 for k=0).
  - out_rem is exact for all DIVISOR; intermediate arithmetic is at least REM_W+1 bits wide.
- Output stability: while out_valid && !out_ready, all out_* hold stable. out_valid never deasserts without a transfer, except on reset.
- Advance: on a transfer that is not the last bit, the next bit is presented the following cycle with prefix_rem updated to the transferred out_rem.
- Last bit:
  - out_last=1 when the bit counter is 1. A single-bit word has out_first=out_last=1.
  - in_ready is also 1 in SHIFT when out_last && out_ready, which gives zero-bubble back-to-back words.
  - If a new word is accepted on the same edge as the last-bit transfer, its first bit appears the next cycle.
  - Otherwise the state goes to IDLE and out_valid=0.
- Remainder scope: the remainder restarts at 0 on every word. No state carries across words.
- in_ready is combinational from state, out_last, out_ready and resetn. It has no path from in_valid.

Test Plan:
- DIVISOR=3, in_data=0x0006, in_len=3, out_ready=1 -> bits 1,1,0 in 3 consecutive cycles:
  - out_rem 1,0,0; out_div 0,1,1.
  - out_first on bit 0, out_last on bit 2.
  - out_valid=0 on the 4th cycle.
- Same word, out_ready low for 2 cycles during bit 1 -> bit 1 (1, rem 0, div 1) held for 3 cycles with all outputs stable, then bit 2 completes normally.
- Back-to-back: 0x0005 len 3 followed by 0x0009 len 4, in_valid held high -> 7 contiguous bits 1,0,1,1,0,0,1 with no gap:
  - rem 1,2,2 then 1,2,1,0.
  - out_first on bits 0 and 3, out_last on bits 2 and 6.
- in_len=0 with in_valid=1 -> accepted in one cycle, out_valid stays 0. in_len=1 with data 1 -> a single bit with out_first=out_last=1, out_rem=1.
- Reset mid-word: 16-bit word 0xFFFF, resetn low after 5 bits -> outputs 0 the next cycle and in_ready=0 during reset. After release, a new word 0x0003 len 2 yields bits 1,1 with rem 1,0.
- DIVISOR=5, 0x0019 (25) len 5 -> bits 1,1,0,0,1; out_rem 1,3,1,2,0; out_div only on the final bit.
